// File: rtl/expo_pkg.sv
// expo_pkg: sizes and loader states shared by mont_expo, the operand loader and the result unloader
package expo_pkg;

    localparam int OP_W   = 192;
    localparam int WORD_W = 32;
    localparam int NWORDS = OP_W / WORD_W;
    localparam int IDX_W  = $clog2(NWORDS);

    localparam logic [1:0] LOAD_X = 2'd0;
    localparam logic [1:0] LOAD_Y = 2'd1;
    localparam logic [1:0] START  = 2'd2;
    localparam logic [1:0] WAIT   = 2'd3;

endpackage

// File: rtl/expo_operand_loader.sv
// expo_operand_loader: assembles x/y from a framed word stream, launches mont_expo and holds operands until done
module expo_operand_loader
    import expo_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic [OP_W-1:0]   x,
    output logic [OP_W-1:0]   y,
    output logic              start,
    input  logic              expo_done,
    output logic              busy,
    output logic              frame_err
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [OP_W-1:0]  x_q, x_d;
    logic [OP_W-1:0]  y_q, y_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;
    logic             done_q, done_d;
    logic             loading, xfer, final_word, bad_frame, done_edge;

    // Word acceptance, framing check, and the start/done handshake with mont_expo
    always_comb begin
        loading     = (state_q == LOAD_X) || (state_q == LOAD_Y);
        xfer        = in_valid && loading;
        final_word  = (state_q == LOAD_Y) && (idx_q == IDX_LAST);
        bad_frame   = xfer && (in_last != final_word);
        done_edge   = expo_done && !done_q;
        done_d      = expo_done;
        frame_err_d = bad_frame;
        x_d         = x_q;
        y_d         = y_q;
        for (int i = 0; i < NWORDS; i++) begin
            if (xfer && !bad_frame && idx_q == IDX_W'(i)) begin
                if (state_q == LOAD_X) x_d[i*WORD_W +: WORD_W] = in_data;
                else                   y_d[i*WORD_W +: WORD_W] = in_data;
            end
        end
        idx_d  = bad_frame ? '0 : xfer ? ((idx_q == IDX_LAST) ? '0 : idx_q + 1'b1) : idx_q;
        busy_d = (state_q == START) ? 1'b1 : (state_q == WAIT && done_edge) ? 1'b0 : busy_q;
        state_d = state_q;
        if (bad_frame)
            state_d = LOAD_X;
        else if (xfer && idx_q == IDX_LAST)
            state_d = (state_q == LOAD_X) ? LOAD_Y : START;
        else if (state_q == START)
            state_d = WAIT;
        else if (state_q == WAIT && done_edge)
            state_d = LOAD_X;
    end

    // State registers; reset aborts any job in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD_X;
            idx_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            y_q         <= y_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = loading && !reset;
    assign start     = (state_q == START) && !reset;
    assign x         = x_q;
    assign y         = y_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_expo_operand_loader.sv
// tb_expo_operand_loader: directed table, corner sequences and random frames against a word-position model
module tb_expo_operand_loader;
    import expo_pkg::*;

    localparam logic [191:0] T1_X = 192'h6543210fedcba9876543210fedcba9876543210fedcba987;
    localparam logic [191:0] T1_Y = 192'hfedcba9876543210fedcba9876543210fedcba9876543210;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, in_last, start, expo_done, busy, frame_err;
    logic [31:0]  in_data;
    logic [191:0] x, y;

    int vectors = 0, miscompares = 0, starts = 0, ferrs = 0;
    logic [3:0] last_ctl;

    int           m_pos;
    bit           m_start, m_wait, m_busy, m_ferr, m_prev_done;
    logic [191:0] m_x, m_y;

    typedef struct {
        bit          v;
        logic [31:0] d;
        bit          l;
        bit          dn;
        logic [3:0]  e;
    } vec_t;
    vec_t tbl[15];

    always #5 clk = ~clk;

    expo_operand_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .x(x), .y(y), .start(start),
        .expo_done(expo_done), .busy(busy), .frame_err(frame_err)
    );

    task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] t1_word(input int w);
        if (w < 6) return (w % 2 == 1) ? 32'h6543210f : 32'hedcba987;
        return (w % 2 == 1) ? 32'hfedcba98 : 32'h76543210;
    endfunction

    task automatic step(input bit r, input bit v, input logic [31:0] d, input bit l, input bit dn);
        reset = r; in_valid = v; in_data = d; in_last = l; expo_done = dn;
        @(negedge clk);
        last_ctl = {in_ready, start, busy, frame_err};
        if (start) starts++;
        if (frame_err) ferrs++;
        if (r) begin
            check("reset_ready_start", 192'({in_ready, start}), 192'(2'b00));
        end else begin
            check("ctl", 192'(last_ctl), 192'({!m_start && !m_wait, m_start, m_busy, m_ferr}));
            check("x", x, m_x);
            check("y", y, m_y);
        end
        if (r) begin
            m_pos = 0; m_start = 1'b0; m_wait = 1'b0; m_busy = 1'b0; m_ferr = 1'b0;
            m_x = '0; m_y = '0;
        end else begin
            m_ferr = 1'b0;
            if (m_start) begin
                m_start = 1'b0; m_wait = 1'b1; m_busy = 1'b1;
            end else if (m_wait) begin
                if (dn && !m_prev_done) begin m_wait = 1'b0; m_busy = 1'b0; end
            end else if (v) begin
                if (l != (m_pos == 2*NWORDS-1)) begin
                    m_ferr = 1'b1; m_pos = 0;
                end else begin
                    if (m_pos < NWORDS) m_x[m_pos*32 +: 32] = d;
                    else                m_y[(m_pos-NWORDS)*32 +: 32] = d;
                    m_pos = (m_pos + 1) % (2*NWORDS);
                    if (m_pos == 0) m_start = 1'b1;
                end
            end
        end
        m_prev_done = r ? 1'b0 : dn;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int nw, input int last_at, input bit gaps, input bit t1, input bit rnd_dn);
        for (int w = 0; w < nw; w++) begin
            while (gaps && $urandom_range(0, 2) == 0) step(1'b0, 1'b0, $urandom, 1'b0, rnd_dn && $urandom_range(0, 1) == 1);
            step(1'b0, 1'b1, t1 ? t1_word(w) : $urandom, w == last_at, rnd_dn && $urandom_range(0, 1) == 1);
        end
    endtask

    task automatic run_job(input int lat);
        step(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < lat; i++) step(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
        step(1'b0, 1'b1, $urandom, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        int s0, e0;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; expo_done = 1'b0;
        @(posedge clk); #1;
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h1234, 1'b0, 1'b1);

        for (int i = 0; i < 12; i++) tbl[i] = '{v: 1'b1, d: t1_word(i), l: (i == 11), dn: 1'b0, e: 4'b1000};
        tbl[12] = '{v: 1'b0, d: 32'h0,        l: 1'b0, dn: 1'b0, e: 4'b0100};
        tbl[13] = '{v: 1'b1, d: 32'hdeadbeef, l: 1'b0, dn: 1'b0, e: 4'b0010};
        tbl[14] = '{v: 1'b1, d: 32'hcafef00d, l: 1'b1, dn: 1'b0, e: 4'b0010};
        s0 = starts;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].dn);
            check($sformatf("tbl%0d_ctl", i), 192'(last_ctl), 192'(tbl[i].e));
        end
        check("t1_x", x, T1_X);
        check("t1_y", y, T1_Y);
        check("t1_one_start", 192'(starts - s0), 192'(1));

        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
        check("t2_busy_before_done", 192'(busy), 192'(1));
        step(1'b0, 1'b1, $urandom, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("t2_ready_after_edge", 192'({in_ready, busy}), 192'(2'b10));
        send_frame(12, 11, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 21; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("t2_stuck_done_busy", 192'(busy), 192'(1));
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        s0 = starts; e0 = ferrs;
        send_frame(5, 4, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t3_frame_err", 192'(ferrs - e0), 192'(1));
        check("t3_no_start", 192'(starts - s0), 192'(0));
        send_frame(12, 11, 1'b0, 1'b1, 1'b0);
        run_job(4);
        check("t3_x", x, T1_X);
        check("t3_y", y, T1_Y);
        check("t3_start", 192'(starts - s0), 192'(1));

        s0 = starts; e0 = ferrs;
        send_frame(12, -1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t4_frame_err", 192'(ferrs - e0), 192'(1));
        check("t4_no_start", 192'(starts - s0), 192'(0));
        check("t4_load_x_ready", 192'(last_ctl[3]), 192'(1));

        send_frame(12, 11, 1'b1, 1'b1, 1'b0);
        run_job(10);
        check("t5_x", x, T1_X);
        check("t5_y", y, T1_Y);

        send_frame(12, 11, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t6_wait_reset", 192'({busy, frame_err, start, |x, |y}), 192'(0));
        send_frame(8, -1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t6_loady_reset", 192'({busy, |x, |y}), 192'(0));
        send_frame(12, 11, 1'b0, 1'b1, 1'b0);
        run_job(2);
        check("t6_x", x, T1_X);
        check("t6_y", y, T1_Y);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0: send_frame(12, $urandom_range(0, 10), 1'b1, 1'b0, 1'b1);
                1: send_frame(12, -1, 1'b1, 1'b0, 1'b1);
                default: begin
                    send_frame(12, 11, 1'b1, 1'b0, 1'b1);
                    run_job($urandom_range(0, 8));
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
